// File: rtl/rr_online_add_if.sv
// rtl/rr_online_add_if.sv - digit-pair input and sum-digit output streams of the online adder
interface rr_online_add_if #(
  parameter int D = 2
);
  logic                in_valid;
  logic                in_first;
  logic                in_ready;
  logic signed [D-1:0] x_digit;
  logic signed [D-1:0] y_digit;
  logic                out_valid;
  logic                out_first;
  logic                out_last;
  logic signed [D-1:0] out_digit;
  logic                err;

  modport master (
    output in_valid, in_first, x_digit, y_digit,
    input  in_ready, out_valid, out_first, out_last, out_digit, err
  );

  modport slave (
    input  in_valid, in_first, x_digit, y_digit,
    output in_ready, out_valid, out_first, out_last, out_digit, err
  );
endinterface

// File: rtl/rr_online_add.sv
// rtl/rr_online_add.sv - MSDF online adder for maximally redundant signed-digit operands
module rr_online_add #(
  parameter int RADIX = 2,
  parameter int WIDTH = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  rr_online_add_if.slave io
);
  localparam int D     = $clog2(RADIX) + 1;
  localparam int DELTA = (RADIX == 2) ? 2 : 1;
  localparam int A     = RADIX - 1;
  localparam int ZW    = D + 2;
  localparam int KW    = $clog2(WIDTH + DELTA + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  localparam logic [KW-1:0] K_ZERO     = '0;
  localparam logic [KW-1:0] K_ONE      = KW'(1);
  localparam logic [KW-1:0] K_LAG      = KW'(DELTA - 1);
  localparam logic [KW-1:0] K_LAST_IN  = KW'(WIDTH - 1);
  localparam logic [KW-1:0] K_LAST_ADV = KW'(WIDTH + DELTA - 1);
  localparam logic [KW-1:0] K_LAST_OUT = KW'(WIDTH);

  localparam logic signed [ZW-1:0] Z_ZERO = '0;
  localparam logic signed [ZW-1:0] Z_P1   = ZW'(1);
  localparam logic signed [ZW-1:0] Z_M1   = ZW'(-1);
  localparam logic signed [ZW-1:0] Z_P2   = ZW'(2);
  localparam logic signed [ZW-1:0] Z_M2   = ZW'(-2);
  localparam logic signed [ZW-1:0] Z_A    = ZW'(A);
  localparam logic signed [ZW-1:0] Z_NA   = ZW'(-A);
  localparam logic signed [ZW-1:0] Z_R    = ZW'(RADIX);

  logic [1:0]           state;
  logic [KW-1:0]        k;
  logic signed [ZW-1:0] z_reg;
  logic signed [ZW-1:0] w_reg;

  logic                 out_valid_r;
  logic                 out_first_r;
  logic                 out_last_r;
  logic signed [D-1:0]  out_digit_r;
  logic                 err_r;

  logic                 ready;
  logic                 accept;
  logic                 restart;
  logic                 advance;
  logic                 emit;
  logic [KW-1:0]        adv_idx;
  logic [KW-1:0]        out_idx;
  logic signed [ZW-1:0] z_new;
  logic signed [ZW-1:0] z_prev;
  logic signed [ZW-1:0] w_prev;
  logic signed [ZW-1:0] t_cur;
  logic signed [ZW-1:0] w_cur;
  logic signed [ZW-1:0] s_cur;

  assign ready   = (state != S_FLUSH);
  assign accept  = io.in_valid && ready;
  assign restart = accept && io.in_first;
  assign advance = restart || (accept && (state == S_RUN)) || (state == S_FLUSH);

  // adv_idx is the index of this advance within the frame; a restart always starts at 0.
  assign adv_idx = restart ? K_ZERO : k;
  assign out_idx = adv_idx - K_LAG;
  assign emit    = advance && ((DELTA == 1) || (adv_idx != K_ZERO));

  assign z_new  = (state == S_FLUSH) ? Z_ZERO : (ZW'(io.x_digit) + ZW'(io.y_digit));
  assign z_prev = (adv_idx == K_ZERO) ? Z_ZERO : z_reg;
  assign w_prev = (adv_idx == K_ZERO) ? Z_ZERO : w_reg;

  // Radix 2 resolves the held position using the incoming digit as lookahead;
  // higher radices resolve the incoming position directly.
  always_comb begin
    t_cur = Z_ZERO;
    w_cur = Z_ZERO;
    if (RADIX == 2) begin
      if (z_prev == Z_P2) begin
        t_cur = Z_P1;
      end else if (z_prev == Z_M2) begin
        t_cur = Z_M1;
      end else if (z_prev == Z_P1) begin
        if (z_new >= Z_ZERO) begin
          t_cur = Z_P1;
          w_cur = Z_M1;
        end else begin
          w_cur = Z_P1;
        end
      end else if (z_prev == Z_M1) begin
        if (z_new >= Z_ZERO) begin
          w_cur = Z_M1;
        end else begin
          t_cur = Z_M1;
          w_cur = Z_P1;
        end
      end
    end else begin
      if (z_new >= Z_A) begin
        t_cur = Z_P1;
        w_cur = z_new - Z_R;
      end else if (z_new <= Z_NA) begin
        t_cur = Z_M1;
        w_cur = z_new + Z_R;
      end else begin
        w_cur = z_new;
      end
    end
  end

  assign s_cur = w_prev + t_cur;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      k           <= K_ZERO;
      z_reg       <= Z_ZERO;
      w_reg       <= Z_ZERO;
      out_valid_r <= 1'b0;
      out_first_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_digit_r <= '0;
      err_r       <= 1'b0;
    end else begin
      out_valid_r <= emit;
      out_first_r <= emit && (out_idx == K_ZERO);
      out_last_r  <= emit && (out_idx == K_LAST_OUT);
      err_r       <= restart && (state != S_IDLE);
      if (emit) begin
        out_digit_r <= s_cur[D-1:0];
      end
      if (advance) begin
        if ((state == S_FLUSH) && (adv_idx == K_LAST_ADV)) begin
          state <= S_IDLE;
          k     <= K_ZERO;
          z_reg <= Z_ZERO;
          w_reg <= Z_ZERO;
        end else begin
          k     <= adv_idx + K_ONE;
          z_reg <= z_new;
          w_reg <= w_cur;
          if ((state == S_FLUSH) || (adv_idx == K_LAST_IN)) begin
            state <= S_FLUSH;
          end else begin
            state <= S_RUN;
          end
        end
      end
    end
  end

  assign io.in_ready  = ready;
  assign io.out_valid = out_valid_r;
  assign io.out_first = out_first_r;
  assign io.out_last  = out_last_r;
  assign io.out_digit = out_digit_r;
  assign io.err       = err_r;
endmodule

// File: doc/rr_online_add.md
# rr_online_add

Digit-serial, most-significant-digit-first (online) adder for radix-RADIX signed-digit operands with maximally redundant digit set {-(RADIX-1)..RADIX-1}. It is the serial successor to the parallel redundant adder and is the first arithmetic block of the MSDF datapath. Each frame accepts two WIDTH-digit operands one digit pair per accepted cycle and emits a WIDTH+1-digit redundant sum, MS digit first, after a fixed online delay. Input stalls are supported, and frames can be aborted.

## Interface
- RADIX, 2: radix r, ≥2; A = r-1; digit width D = clog2(RADIX)+1, two's complement.
- WIDTH, 6: digits per input operand; output frame has WIDTH+1 digits.
- DELTA (localparam): online delay; 2 if RADIX==2, else 1.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  digit pair present on x_digit/y_digit.
- in_first  in  1  qualifies in_valid; marks the MS digit of a new frame.
- in_ready  out  1  block accepts a digit this cycle.
- x_digit, y_digit  in  D  signed operand digits in [-A, A].
- out_valid  out  1  out_digit holds a sum digit.
- out_first, out_last  out  1  mark output digit 0 (weight r^WIDTH) and digit WIDTH (weight r^0).
- out_digit  out  D  signed sum digit in [-A, A].
- err  out  1  one-cycle pulse: frame aborted by an early in_first.

## Operation
- States: IDLE, RUN, FLUSH. A digit pair is accepted when in_valid & in_ready. Digit counter k counts accepted digits 0..WIDTH-1.
- In IDLE, an accept with in_first loads k=1 and moves to RUN. An accept without in_first is discarded.
- In RUN, each accept increments k. When the WIDTH-th digit is accepted, move to FLUSH.
- FLUSH runs for DELTA cycles. Each cycle the pipeline is fed zero digits. Then return to IDLE.
- in_ready = 1 in IDLE and RUN, 0 in FLUSH.
- Per position: z = x+y ∈ [-2A, 2A]. Sum digit s_p = w_p + t_(p-1), where t is a transfer digit in {-1,0,1}.
- RADIX ≥ 3: t=1, w=z-r if z ≥ A; t=-1, w=z+r if z ≤ -A; else t=0, w=z.
- RADIX = 2: z=±2 gives t=±1, w=0; z=0 gives t=0, w=0.
- RADIX = 2, z=1: if the next-lower z ≥ 0, t=1, w=-1; else t=0, w=1.
- RADIX = 2, z=-1: if the next-lower z ≥ 0, t=0, w=-1; else t=-1, w=1.
- The position above the MS input digit has w=0, so output digit 0 = t of the MS position. Flush zeros count as next-lower z=0.
- The pipeline advances only on accepted cycles and FLUSH cycles. A stalled cycle holds all state and drives out_valid=0.
- in_first accepted during RUN or FLUSH:
  - The current frame is dropped and err pulses.
  - Pipeline registers and k are reinitialised, and the digit starts a new frame in RUN.
  - No out_last is issued for the dropped frame.
- out_digit always lies in [-A, A]. The numeric value of the output frame equals X+Y exactly.

## Timing
- Reset values: state=IDLE, k=0, all pipeline registers 0; out_valid=0, out_first=0, out_last=0, out_digit=0, err=0, in_ready=1.
- Reset is asynchronous and may assert mid-frame. The partial frame is lost, and no output follows deassertion until a new in_first.
- Output digit j (0..WIDTH) is registered on the pipeline advance that accepts input digit j+DELTA-1, or on the corresponding FLUSH cycle. It is visible in the following cycle.
- Without stalls:
  - Output digit 0 appears DELTA cycles after the first accept.
  - out_valid is high for WIDTH+1 consecutive cycles.
  - The frame occupies WIDTH+DELTA cycles.
- The next frame's in_first is accepted on the first cycle after FLUSH.
- err is registered and appears one cycle after the offending accept.

## Test plan
- RADIX=2, WIDTH=6, x=y=all +1 (63+63), no stalls: 7 digits valued 126, out_first on the first and out_last on the seventh, 8 cycles from first accept to out_last.
- RADIX=4, WIDTH=6, x=y=all +3 (4095 each): sum value 8190, every digit in [-3,3], output digit 0 one cycle after the first accept.
- RADIX=2, x=+1,-1,0,+1,-1,-1 and y=-1,-1,+1,+1,0,-1, with in_valid low for 2 cycles after digits 1 and 4: sum value correct, and out_valid low exactly on the stalled cycles.
- in_first reasserted after 3 digits of a frame: err pulses once, the first frame produces no out_last, and the second frame's sum is correct.
- rst_n low for one cycle mid-RUN: all outputs return to reset values immediately, and the next frame is correct.
- 1000 random frames each for RADIX 2, 4 and 8, WIDTH 6, with random stalls: every output frame value equals X+Y, all digits are in range, and in_ready=0 in exactly DELTA cycles per frame.
